// File: rtl/palette_selector_if.sv
// palette_selector_if: button, auto-cycle and frame inputs plus committed palette outputs
interface palette_selector_if;
    logic       btn_next;
    logic       btn_prev;
    logic       auto_en;
    logic       frame_start;
    logic [7:0] color_id;
    logic       pending;
    logic       changed;
    modport master (output btn_next, btn_prev, auto_en, frame_start, input color_id, pending, changed);
    modport slave (input btn_next, btn_prev, auto_en, frame_start, output color_id, pending, changed);
endinterface

// File: rtl/palette_selector.sv
// palette_selector: debounced next/prev and auto-cycle palette target, committed only on frame_start
module palette_selector #(
    parameter int NUM_PALETTES    = 3,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int AUTO_FRAMES     = 120
) (
    input logic               clk,
    input logic               rst_n,
    palette_selector_if.slave bus
);
    localparam int DW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int FW = AUTO_FRAMES > 1 ? $clog2(AUTO_FRAMES) : 1;
    localparam logic [DW-1:0] D_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [FW-1:0] F_LAST  = FW'(AUTO_FRAMES - 1);
    localparam logic [7:0]    ID_LAST = 8'(NUM_PALETTES - 1);

    logic [1:0]         s1_q, s2_q, db_q, db_d, req;
    logic [1:0][DW-1:0] cnt_q, cnt_d;
    logic [FW-1:0]      frame_q, frame_d;
    logic [7:0]         target_q, target_d, color_q, color_d, inc_id, dec_id;
    logic               pending_q, pending_d, changed_q, changed_d, commit;

    // Bit 0 is next, bit 1 is prev; a request fires in the cycle the debounced level rises.
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        req   = '0;
        for (int i = 0; i < 2; i++) begin
            if (s2_q[i] != db_q[i]) begin
                if (cnt_q[i] == D_LAST) begin
                    db_d[i] = ~db_q[i];
                    req[i]  = ~db_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign inc_id = (target_q == ID_LAST) ? 8'd0 : target_q + 8'd1;
    assign dec_id = (target_q == 8'd0) ? ID_LAST : target_q - 8'd1;
    assign commit = bus.frame_start && (target_q != color_q);

    always_comb begin
        target_d  = target_q;
        frame_d   = frame_q;
        if (req[0] != req[1]) begin
            target_d = req[0] ? inc_id : dec_id;
            frame_d  = '0;
        end else if (!req[0] && bus.auto_en && bus.frame_start) begin
            target_d = (frame_q == F_LAST) ? inc_id : target_q;
            frame_d  = (frame_q == F_LAST) ? '0 : frame_q + 1'b1;
        end
        if (!bus.auto_en)
            frame_d = '0;
        color_d   = commit ? target_q : color_q;
        changed_d = commit;
        pending_d = target_q != color_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q      <= '0;
            s2_q      <= '0;
            db_q      <= '0;
            cnt_q     <= '0;
            frame_q   <= '0;
            target_q  <= '0;
            color_q   <= '0;
            pending_q <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            s1_q      <= {bus.btn_prev, bus.btn_next};
            s2_q      <= s1_q;
            db_q      <= db_d;
            cnt_q     <= cnt_d;
            frame_q   <= frame_d;
            target_q  <= target_d;
            color_q   <= color_d;
            pending_q <= pending_d;
            changed_q <= changed_d;
        end
    end

    assign bus.color_id = color_q;
    assign bus.pending  = pending_q;
    assign bus.changed  = changed_q;
endmodule

// File: tb/tb_palette_selector.sv
// tb_palette_selector: directed stimulus with a per-cycle reference model and literal checkpoints
module tb_palette_selector;
    localparam int NP = 3, DB = 4, AF = 3, FP = 20;

    logic clk = 1'b0, rst_n = 1'b0;
    palette_selector_if bus ();
    palette_selector #(.NUM_PALETTES(NP), .DEBOUNCE_CYCLES(DB), .AUTO_FRAMES(AF)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0, fcnt = 0, chg_cnt = 0, c0 = 0, lat = 0;
    bit fs_en = 0;
    int m_target = 0, m_color = 0, m_fc = 0, m_cyc = 0, m_last = -100;
    int m_run [2];
    bit m_raw [2], m_db [2], m_req [2], m_raw_now [2];
    bit m_pending = 0, m_changed = 0, m_commit = 0;
    int exp_seq [3] = '{1, 2, 0};

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference: a button level is accepted once the raw input has held it for 2 sync + DB cycles.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_target = 0; m_color = 0; m_fc = 0; m_pending = 0; m_changed = 0;
            m_cyc = 0; m_last = -100;
            for (int i = 0; i < 2; i++) begin m_run[i] = 0; m_raw[i] = 0; m_db[i] = 0; end
        end else begin
            m_cyc++;
            m_raw_now[0] = bus.btn_next;
            m_raw_now[1] = bus.btn_prev;
            for (int i = 0; i < 2; i++) begin
                m_run[i] = (m_raw_now[i] == m_raw[i]) ? m_run[i] + 1 : 1;
                m_raw[i] = m_raw_now[i];
                m_req[i] = 0;
                if (m_raw[i] != m_db[i] && m_run[i] == DB + 2) begin
                    m_db[i] = m_raw[i];
                    m_req[i] = m_raw[i];
                    m_last = m_cyc;
                end
            end
            m_commit  = bus.frame_start && (m_target != m_color);
            m_pending = m_target != m_color;
            m_changed = m_commit;
            if (m_commit) m_color = m_target;
            if (m_req[0] && m_req[1]) begin
            end else if (m_req[0]) begin
                m_target = (m_target + 1) % NP; m_fc = 0;
            end else if (m_req[1]) begin
                m_target = (m_target + NP - 1) % NP; m_fc = 0;
            end else if (bus.auto_en && bus.frame_start) begin
                m_fc++;
                if (m_fc == AF) begin m_fc = 0; m_target = (m_target + 1) % NP; end
            end
            if (!bus.auto_en) m_fc = 0;
        end
    end

    initial forever begin
        @(negedge clk);
        chk("color_id", bus.color_id, m_color);
        chk("changed", bus.changed, m_changed);
        if (m_raw[0] == m_db[0] && m_raw[1] == m_db[1] && m_cyc - m_last >= 2)
            chk("pending", bus.pending, m_pending);
        if (bus.changed) chg_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
        fcnt = (fcnt + 1) % FP;
        bus.frame_start = fs_en && fcnt == 0;
    endtask

    task automatic to_phase(input int p);
        while (fcnt != p) step();
    endtask

    task automatic next_frame();
        do step(); while (fcnt != 0);
        repeat (3) step();
    endtask

    task automatic press(input bit nx, input bit pv, input int hold);
        bus.btn_next = nx;
        bus.btn_prev = pv;
        repeat (hold) step();
        bus.btn_next = 0;
        bus.btn_prev = 0;
        repeat (hold) step();
    endtask

    task automatic do_reset();
        #2 rst_n = 0;
        fs_en = 0;
        bus.btn_next = 0; bus.btn_prev = 0; bus.auto_en = 0; bus.frame_start = 0;
        repeat (3) step();
        rst_n = 1; fcnt = 0; fs_en = 1;
    endtask

    initial begin
        bus.btn_next = 0; bus.btn_prev = 0; bus.auto_en = 0; bus.frame_start = 0;
        repeat (3) step();
        rst_n = 1; fcnt = 0; fs_en = 1;
        chk("reset color_id", bus.color_id, 0);
        chk("reset pending", bus.pending, 0);
        chk("reset changed", bus.changed, 0);

        step();
        bus.btn_next = 1;
        lat = 0;
        while (!bus.pending && lat < 20) begin step(); lat++; end
        chk("press latency within window", int'(lat >= DB + 2 && lat <= DB + 4), 1);
        repeat (10 - lat) step();
        bus.btn_next = 0;
        c0 = chg_cnt;
        next_frame();
        chk("clean press commit", bus.color_id, 1);
        chk("clean press one changed pulse", chg_cnt - c0, 1);
        chk("clean press pending cleared", bus.pending, 0);

        do_reset();
        step();
        for (int i = 0; i < 6; i++) begin bus.btn_next = !bus.btn_next; step(); step(); end
        bus.btn_next = 1;
        c0 = chg_cnt;
        repeat (7) step();
        bus.btn_next = 0;
        next_frame();
        chk("bounce single request", bus.color_id, 1);
        chk("bounce one changed pulse", chg_cnt - c0, 1);

        do_reset();
        for (int i = 0; i < 3; i++) begin
            to_phase(1);
            press(1, 0, 7);
            next_frame();
            chk("next wrap sequence", bus.color_id, exp_seq[i]);
        end

        do_reset();
        to_phase(1);
        press(0, 1, 7);
        next_frame();
        chk("prev from reset", bus.color_id, 2);
        to_phase(1);
        c0 = chg_cnt;
        press(1, 1, 7);
        next_frame();
        chk("next+prev cancel color", bus.color_id, 2);
        chk("next+prev cancel pending", bus.pending, 0);
        chk("next+prev cancel no pulse", chg_cnt - c0, 0);

        do_reset();
        to_phase(1);
        c0 = chg_cnt;
        press(1, 0, 6);
        press(1, 0, 6);
        to_phase(10);
        chk("two presses one frame", bus.color_id, 2);
        chk("two presses single pulse", chg_cnt - c0, 1);

        do_reset();
        bus.auto_en = 1;
        repeat (3) next_frame();
        chk("auto after 3 frames", bus.color_id, 0);
        next_frame();
        chk("auto after 4 frames", bus.color_id, 1);
        repeat (3) next_frame();
        chk("auto after 7 frames", bus.color_id, 2);
        repeat (3) next_frame();
        chk("auto after 10 frames", bus.color_id, 0);
        next_frame();
        to_phase(5);
        press(1, 0, 6);
        next_frame();
        chk("auto press commit", bus.color_id, 1);
        next_frame();
        chk("auto counter cleared by press", bus.color_id, 1);
        next_frame();
        chk("auto advance not yet committed", bus.color_id, 1);
        next_frame();
        chk("auto advance 3 frames after press", bus.color_id, 2);
        bus.auto_en = 0;

        do_reset();
        to_phase(1);
        press(1, 0, 7);
        next_frame();
        to_phase(1);
        press(1, 0, 7);
        step();
        chk("pre-reset color_id", bus.color_id, 1);
        chk("pre-reset pending", bus.pending, 1);
        #2 rst_n = 0;
        #1;
        chk("async reset color_id", bus.color_id, 0);
        chk("async reset pending", bus.pending, 0);
        chk("async reset changed", bus.changed, 0);
        repeat (3) step();
        rst_n = 1;
        c0 = chg_cnt;
        next_frame();
        next_frame();
        chk("post-reset color_id", bus.color_id, 0);
        chk("post-reset no pulse", chg_cnt - c0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
